// File: rtl/dither_pkg.sv
// Shared types and constants for the frame loader and dither path.
package dither_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } loader_state_e;

  // BT.601-style luma weights scaled so that they sum to 256
  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

endpackage

// File: rtl/luma_conv.sv
// Combinational RGB-to-gray conversion, (77R + 150G + 29B) >> 8, truncating.
// Only compiled when GRAY_CONV_EN is defined.
`ifdef GRAY_CONV_EN
module luma_conv
  import dither_pkg::*;
#(
  parameter int RGB_SIZE = 8
) (
  input  logic [3*RGB_SIZE-1:0] rgb,
  output logic [RGB_SIZE-1:0]   luma
);

  localparam int ACC_W = RGB_SIZE + 8;

  logic [ACC_W-1:0] acc;

  // Weights sum to 256, so the accumulator can never overflow
  always_comb begin
    acc  = ACC_W'(LUMA_R) * ACC_W'(rgb[0*RGB_SIZE +: RGB_SIZE])
         + ACC_W'(LUMA_G) * ACC_W'(rgb[1*RGB_SIZE +: RGB_SIZE])
         + ACC_W'(LUMA_B) * ACC_W'(rgb[2*RGB_SIZE +: RGB_SIZE]);
    luma = RGB_SIZE'(acc >> 8);
  end

endmodule
`endif

// File: rtl/pixel_frame_loader.sv
// Loads one frame of CHANNELS-byte pixels from a byte stream into the frame SRAM.
// Optional macro GRAY_CONV_EN stores one luma byte per pixel instead of the raw channels.
module pixel_frame_loader
  import dither_pkg::*;
#(
  parameter int IMAGEX           = 16,
  parameter int IMAGEY           = 16,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8,
  parameter int CHANNELS         = 3,
`ifdef GRAY_CONV_EN
  localparam int OUT_W           = RGB_SIZE
`else
  localparam int OUT_W           = CHANNELS * RGB_SIZE
`endif
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [RGB_SIZE-1:0]         in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        sram_we,
  output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
  output logic [OUT_W-1:0]            sram_wdata,
  output logic                        busy,
  output logic                        done
);

  localparam int PIX_W  = CHANNELS * RGB_SIZE;
  localparam int BUF_W  = (CHANNELS > 1) ? (CHANNELS - 1) * RGB_SIZE : RGB_SIZE;
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CHAN_W-1:0]           LAST_CHAN = CHAN_W'(CHANNELS - 1);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_PIX  = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

  loader_state_e               state;
  logic [CHAN_W-1:0]           chan_cnt;
  logic [IMAGE_ADDR_WIDTH-1:0] pix_cnt;
  logic [BUF_W-1:0]            chan_buf;
  logic [PIX_W-1:0]            pixel;
  logic [OUT_W-1:0]            pix_word;

  assign in_ready = (state == RECV) && !abort;
  assign busy     = (state == RECV);

  // The last channel is taken straight from the bus so the write lands one cycle later
  generate
    if (CHANNELS > 1) begin : g_multi
      assign pixel = {in_data, chan_buf};
    end else begin : g_single
      assign pixel = in_data;
    end
  endgenerate

`ifdef GRAY_CONV_EN
  luma_conv #(.RGB_SIZE(RGB_SIZE)) u_luma_conv (
    .rgb  (pixel),
    .luma (pix_word)
  );
`else
  assign pix_word = pixel;
`endif

  // Frame FSM, channel/pixel counters and registered SRAM port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      chan_cnt   <= '0;
      pix_cnt    <= '0;
      chan_buf   <= '0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      done       <= 1'b0;
    end else begin
      sram_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state    <= RECV;
            chan_cnt <= '0;
            pix_cnt  <= '0;
          end
        end
        RECV: begin
          if (abort) begin
            state    <= IDLE;
            chan_cnt <= '0;
            pix_cnt  <= '0;
          end else if (in_valid) begin
            if (chan_cnt == LAST_CHAN) begin
              sram_we    <= 1'b1;
              sram_addr  <= pix_cnt;
              sram_wdata <= pix_word;
              chan_cnt   <= '0;
              if (pix_cnt == LAST_PIX) begin
                state   <= DONE;
                pix_cnt <= '0;
              end else begin
                pix_cnt <= pix_cnt + IMAGE_ADDR_WIDTH'(1);
              end
            end else begin
              chan_buf[int'(chan_cnt) * RGB_SIZE +: RGB_SIZE] <= in_data;
              chan_cnt <= chan_cnt + CHAN_W'(1);
            end
          end
        end
        // DONE covers the final write cycle; the done pulse follows it
        DONE: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed bench for pixel_frame_loader (4x4, 3 channels) with a byte-queue reference model.
module tb_pixel_frame_loader;

`ifdef GRAY_CONV_EN
  localparam int OW = 8;
`else
  localparam int OW = 24;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          sram_we;
  logic [3:0]    sram_addr;
  logic [OW-1:0] sram_wdata;
  logic          busy;
  logic          done;

  int total = 0;
  int bad = 0;

  pixel_frame_loader #(
    .IMAGEX(4), .IMAGEY(4), .RGB_SIZE(8), .CHANNELS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [OW-1:0] model_pix(input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
`ifdef GRAY_CONV_EN
    int y;
    y = (77 * int'(r) + 150 * int'(g) + 29 * int'(b)) / 256;
    return OW'(y);
`else
    return {b, g, r};
`endif
  endfunction

  // Reference model: a frame is active, bytes queue up, every third byte makes a write
  bit            m_active = 1'b0;
  bit            m_fin = 1'b0;
  bit            was_fin;
  int            m_bytes = 0;
  logic [7:0]    pend[$];
  logic          exp_we = 1'b0;
  logic          exp_done = 1'b0;
  logic [3:0]    exp_addr = 4'd0;
  logic [OW-1:0] exp_data = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0; m_fin = 1'b0; m_bytes = 0; pend.delete();
      exp_we = 1'b0; exp_done = 1'b0; exp_addr = 4'd0; exp_data = '0;
    end else begin
      exp_done = m_fin;
      was_fin  = m_fin;
      m_fin    = 1'b0;
      exp_we   = 1'b0;
      if (m_active) begin
        if (abort) begin
          m_active = 1'b0; m_bytes = 0; pend.delete();
        end else if (in_valid) begin
          pend.push_back(in_data);
          m_bytes++;
          if (pend.size() == 3) begin
            exp_we   = 1'b1;
            exp_addr = 4'(m_bytes / 3 - 1);
            exp_data = model_pix(pend[0], pend[1], pend[2]);
            pend.delete();
            if (m_bytes == 48) begin
              m_active = 1'b0; m_fin = 1'b1; m_bytes = 0;
            end
          end
        end
      end else if (!was_fin && start && !abort) begin
        m_active = 1'b1; m_bytes = 0; pend.delete();
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("in_ready", in_ready, m_active && !abort);
    check("sram_we", sram_we, exp_we);
    check("busy", busy, m_active);
    check("done", done, exp_done);
    check("sram_addr", sram_addr, exp_addr);
    check("sram_wdata", sram_wdata, exp_data);
  end

  // Event counters and a shadow copy of the SRAM
  int acc_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [OW-1:0] mem [16];

  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
    if (sram_we) begin
      wr_cnt++;
      mem[sram_addr] = sram_wdata;
    end
    if (done) done_cnt++;
  end

  function automatic logic [7:0] frame_byte(input int kind, input int i);
    int k;
    int c;
    k = i / 3;
    c = i % 3;
    if (kind == 0) return 8'(k + c);
    case (k)
      0:       return 8'hFF;
      1:       return (c == 0) ? 8'hFF : 8'h00;
      2:       return (c == 2) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit rnd);
    bit taken;
    int tries;
    taken = 1'b0;
    tries = 0;
    while (!taken && tries < 100) begin
      in_data  = b;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      taken = in_valid && in_ready;
      tick();
      tries++;
    end
    in_valid = 1'b0;
    check("byte_accepted", taken, 1'b1);
  endtask

  task automatic run_frame(input int kind, input bit rnd);
    int w0;
    int d0;
    int guard;
    w0 = wr_cnt;
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 48; i++) push_byte(frame_byte(kind, i), rnd);
    guard = 0;
    while (done_cnt == d0 && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    check("frame_writes", wr_cnt - w0, 16);
    check("frame_done_count", done_cnt - d0, 1);
  endtask

  task automatic check_ramp_mem();
`ifdef GRAY_CONV_EN
    check("ramp_mem0", mem[0], 8'h00);
    check("ramp_mem5", mem[5], 8'h05);
    check("ramp_mem15", mem[15], 8'h0F);
`else
    check("ramp_mem0", mem[0], 24'h020100);
    check("ramp_mem5", mem[5], 24'h070605);
    check("ramp_mem15", mem[15], 24'h11100F);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int d0;
    int a0;

    // Power-on reset
    repeat (3) tick();
    check("reset_we", sram_we, 1'b0);
    check("reset_ready", in_ready, 1'b0);
    check("reset_addr", sram_addr, 4'd0);
    check("reset_wdata", sram_wdata, '0);
    reset_n = 1'b1;
    tick();

    // Back-to-back ramp frame
    clear_mem();
    run_frame(0, 1'b0);
    check_ramp_mem();

    // Luma/packing corner pixels
    clear_mem();
    run_frame(1, 1'b0);
`ifdef GRAY_CONV_EN
    check("px_white", mem[0], 8'hFF);
    check("px_red", mem[1], 8'h4C);
    check("px_blue", mem[2], 8'h1C);
    check("px_black", mem[3], 8'h00);
`else
    check("px_white", mem[0], 24'hFFFFFF);
    check("px_red", mem[1], 24'h0000FF);
    check("px_blue", mem[2], 24'hFF0000);
    check("px_black", mem[3], 24'h000000);
`endif

    // Random in_valid stalls
    clear_mem();
    run_frame(0, 1'b1);
    check_ramp_mem();

    // Abort after 20 bytes, then a fresh frame
    w0 = wr_cnt;
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 20; i++) push_byte(frame_byte(0, i), 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    check("abort_writes", wr_cnt - w0, 6);
    check("abort_done", done_cnt - d0, 0);
    check("abort_busy", busy, 1'b0);
    clear_mem();
    run_frame(0, 1'b0);
    check_ramp_mem();

    // Overrun with a stray start mid-frame
    a0 = acc_cnt;
    w0 = wr_cnt;
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      in_data  = frame_byte(0, i % 48);
      in_valid = 1'b1;
      start    = (i == 10);
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (3) tick();
    check("overrun_accepted", acc_cnt - a0, 48);
    check("overrun_writes", wr_cnt - w0, 16);
    check("overrun_done", done_cnt - d0, 1);

    // Asynchronous reset mid-frame with start held
    pulse_start();
    for (int i = 0; i < 10; i++) push_byte(frame_byte(0, i), 1'b0);
    @(posedge clk);
    #5;
    reset_n = 1'b0;
    start   = 1'b1;
    #1;
    check("arst_ready", in_ready, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_addr", sram_addr, 4'd0);
    check("arst_wdata", sram_wdata, '0);
    repeat (3) tick();
    check("arst_start_ignored", busy, 1'b0);
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (2) tick();
    check("arst_idle", busy, 1'b0);
    clear_mem();
    run_frame(0, 1'b0);
    check_ramp_mem();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
